// File: rtl/semiring_pkg.sv
// Semiring op enum, mode decode and min/max identities.
// SEMIRING_PLUS_EN enables the saturating-add (tropical) modes.
package semiring_pkg;

    typedef enum logic [1:0] {
        OP_MIN_MAX  = 2'd0,
        OP_MAX_MIN  = 2'd1,
        OP_MIN_PLUS = 2'd2,
        OP_MAX_PLUS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        PAIR_MIN = 2'd0,
        PAIR_MAX = 2'd1,
        PAIR_ADD = 2'd2
    } pair_e;

    typedef enum logic {
        RED_MIN = 1'b0,
        RED_MAX = 1'b1
    } red_e;

    typedef struct packed {
        pair_e pair;
        red_e  red;
        logic  err;
    } mode_t;

    localparam int IDW = 32;
    localparam logic [IDW-1:0] MIN_ID = '1;
    localparam logic [IDW-1:0] MAX_ID = '0;

    function automatic mode_t decode(op_e op);
        mode_t m;
        m = '{PAIR_MIN, RED_MAX, 1'b0};
        case (op)
            OP_MAX_MIN:  m = '{PAIR_MAX, RED_MIN, 1'b0};
`ifdef SEMIRING_PLUS_EN
            OP_MIN_PLUS: m = '{PAIR_ADD, RED_MIN, 1'b0};
            OP_MAX_PLUS: m = '{PAIR_ADD, RED_MAX, 1'b0};
`else
            // plus modes fall back to MIN_MAX and flag it
            OP_MIN_PLUS,
            OP_MAX_PLUS: m.err = 1'b1;
`endif
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/semiring_dot_pipe_if.sv
// Beat-in / result-out handshake bundle for semiring_dot_pipe.
// master drives beats, slave is the pipeline.
interface semiring_dot_pipe_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int CW = 8
);
    logic           in_valid;
    logic           in_ready;
    logic           in_first;
    logic           in_last;
    logic [1:0]     in_op;
    logic [N*W-1:0] in_a;
    logic [N*W-1:0] in_b;
    logic [W-1:0]   in_c;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_cnt;
    logic           out_err;

    modport master (
        output in_valid, in_first, in_last, in_op,
        output in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_err
    );

    modport slave (
        input  in_valid, in_first, in_last, in_op,
        input  in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_err
    );
endinterface

// File: rtl/semiring_reduce_tree.sv
// Combinational log2(N)-level min/max reduction tree.
module semiring_reduce_tree
    import semiring_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic [N*W-1:0] x,
    input  red_e           red,
    output logic [W-1:0]   y
);
    localparam int L = $clog2(N);

    function automatic logic [W-1:0] pick(
        input logic [W-1:0] p,
        input logic [W-1:0] q,
        input red_e         r
    );
        if (r == RED_MAX) return (p > q) ? p : q;
        return (p < q) ? p : q;
    endfunction

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        logic [W-1:0] v [N>>l];
        for (genvar i = 0; i < (N >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign v[i] = x[i*W +: W];
            end else begin : g_op
                assign v[i] = pick(g_lvl[l-1].v[2*i],
                                   g_lvl[l-1].v[2*i+1], red);
            end
        end
    end

    assign y = g_lvl[L].v[0];
endmodule

// File: rtl/semiring_dot_pipe.sv
// Two-stage semiring dot product: pair ops, then tree + accumulate.
// SEMIRING_PLUS_EN enables MIN_PLUS/MAX_PLUS with saturating adds.
module semiring_dot_pipe
    import semiring_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int CW = 8
) (
    input logic               clk,
    input logic               rst_n,
    semiring_dot_pipe_if.slave bus
);
    logic           en;
    logic           take;
    logic           first;
    logic           open;
    op_e            cur_op;
    op_e            op_eff;
    mode_t          mode;
    logic [N*W-1:0] pair_d;

    logic           s1_v;
    logic           s1_first;
    logic           s1_last;
    logic           s1_err;
    red_e           s1_red;
    logic [W-1:0]   s1_c;
    logic [N*W-1:0] s1_pair;

    logic [W-1:0]   tree;
    logic [W-1:0]   base;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;

    function automatic logic [W-1:0] pair_fn(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input pair_e        p
    );
`ifdef SEMIRING_PLUS_EN
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (p == PAIR_ADD) return s[W] ? MIN_ID[W-1:0] : s[W-1:0];
`endif
        if (p == PAIR_MAX) return (a > b) ? a : b;
        return (a < b) ? a : b;
    endfunction

    // one stall signal freezes both stages
    assign en = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign take = bus.in_valid && en;
    assign first = bus.in_first || !open;
    assign op_eff = first ? op_e'(bus.in_op) : cur_op;
    assign mode = decode(op_eff);

    always_comb begin
        pair_d = '0;
        for (int i = 0; i < N; i++) begin
            pair_d[i*W +: W] = pair_fn(bus.in_a[i*W +: W],
                                       bus.in_b[i*W +: W],
                                       mode.pair);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_red   <= RED_MIN;
            s1_c     <= '0;
            s1_pair  <= '0;
            open     <= 1'b0;
            cur_op   <= OP_MIN_MAX;
        end else if (en) begin
            s1_v <= take;
            if (take) begin
                s1_first <= first;
                s1_last  <= bus.in_last;
                s1_err   <= mode.err;
                s1_red   <= mode.red;
                s1_c     <= bus.in_c;
                s1_pair  <= pair_d;
                open     <= !bus.in_last;
                cur_op   <= op_eff;
            end
        end
    end

    semiring_reduce_tree #(
        .W(W),
        .N(N)
    ) u_tree (
        .x  (s1_pair),
        .red(s1_red),
        .y  (tree)
    );

    always_comb begin
        base = s1_first ? s1_c : acc;
        if (s1_red == RED_MAX) acc_nxt = (base > tree) ? base : tree;
        else acc_nxt = (base < tree) ? base : tree;
        if (s1_first) cnt_nxt = CW'(1);
        else cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= MAX_ID[W-1:0];
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_cnt   <= '0;
            bus.out_err   <= 1'b0;
        end else if (en) begin
            bus.out_valid <= s1_v && s1_last;
            if (s1_v) begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                if (s1_last) begin
                    bus.out_data <= acc_nxt;
                    bus.out_cnt  <= cnt_nxt;
                    bus.out_err  <= s1_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_semiring_dot_pipe.sv
// Directed bench for semiring_dot_pipe (W=16, N=4, CW=8).
// Expectations adapt to whether SEMIRING_PLUS_EN is defined.
module tb_semiring_dot_pipe;
`ifdef SEMIRING_PLUS_EN
    localparam bit PLUS = 1'b1;
`else
    localparam bit PLUS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_asrt = 0;
    int   n_fail = 0;

    semiring_dot_pipe_if #(.W(16), .N(4), .CW(8)) bus ();

    semiring_dot_pipe #(.W(16), .N(4), .CW(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pk(input logic [15:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic f, input logic l, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] c);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk("send_timeout", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [15:0] d,
                          input logic [7:0] c, input logic e);
        int cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_lat"}, cyc, 1);
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_cnt"}, 32'(bus.out_cnt), 32'(c));
        chk({tag, "_err"}, 32'(bus.out_err), 32'(e));
        @(posedge clk); #1;
        chk({tag, "_once"}, 32'(bus.out_valid), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, "_rvalid"}, 32'(bus.out_valid), 0);
        chk({tag, "_rdata"}, 32'(bus.out_data), 0);
        chk({tag, "_rcnt"}, 32'(bus.out_cnt), 0);
        chk({tag, "_rerr"}, 32'(bus.out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ready"}, 32'(bus.in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_quiet"}, 32'(bus.out_valid), 0);
            @(posedge clk); #1;
        end
    endtask

    logic [63:0] a1, b1, a7, a4, b2, aff, b20, one, junk;

    initial begin
        a1   = pk(3, 9, 5, 1);
        b1   = pk(7, 2, 8, 6);
        a7   = pk(7, 7, 7, 7);
        a4   = pk(4, 4, 4, 4);
        b2   = pk(2, 2, 2, 2);
        aff  = pk(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0);
        b20  = pk(16'h0020, 16'h0020, 16'h0020, 16'h0020);
        one  = pk(1, 1, 1, 1);
        junk = pk(100, 100, 100, 100);
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b1;
        #1;
        do_reset("init");

        // MIN_MAX single beat
        send(1, 1, 0, a1, b1, 0);
        result("minmax", 16'd5, 8'd1, 1'b0);

        // MIN_PLUS two beats
        send(1, 0, 2, pk(1, 2, 3, 4), pk(10, 1, 5, 0), 16'hFFFF);
        send(0, 1, 2, one, pk(1, 9, 9, 9), 0);
        result("minplus", PLUS ? 16'd2 : 16'hFFFF, 8'd2, !PLUS);

        // saturating add
        send(1, 1, 2, aff, b20, 16'hFFFF);
        result("sat", 16'hFFFF, 8'd1, !PLUS);

        // op 2 on the MIN_MAX vector
        send(1, 1, 2, a1, b1, 0);
        result("op2", PLUS ? 16'd0 : 16'd5, 8'd1, !PLUS);

        // restart with in_first while a product is open
        send(1, 0, 0, a1, b1, 0);
        send(1, 1, 1, a7, a7, 7);
        result("restart", 16'd7, 8'd1, 1'b0);

        // no in_first with nothing open acts as first
        send(0, 1, 0, a1, b1, 0);
        result("implfirst", 16'd5, 8'd1, 1'b0);

        // backpressure with a second beat queued behind
        bus.out_ready = 1'b0;
        send(1, 1, 0, a1, b1, 0);
        send(1, 1, 1, a4, b2, 9);
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_op    = 2'd0;
        bus.in_a     = junk;
        bus.in_b     = junk;
        bus.in_c     = 16'd0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(bus.in_ready), 0);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 5);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp2_valid", 32'(bus.out_valid), 1);
        chk("bp2_data", 32'(bus.out_data), 4);
        chk("bp2_cnt", 32'(bus.out_cnt), 1);
        @(posedge clk); #1;
        chk("bp_nodup", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk("bp_nojunk", 32'(bus.out_valid), 0);

        // beat counter saturation over 300 beats
        send(1, 0, 0, one, one, 0);
        for (int i = 0; i < 298; i++) send(0, 0, 0, one, one, 0);
        send(0, 1, 0, one, one, 0);
        result("cntsat", 16'd1, 8'd255, 1'b0);

        // reset with the last beat in flight
        send(1, 0, 0, a1, b1, 0);
        send(0, 1, 0, a1, b1, 0);
        do_reset("rstlast");

        // reset with a product open: next beat must start fresh
        send(1, 0, 0, a1, b1, 0);
        do_reset("rstopen");
        send(0, 1, 0, a1, b1, 9);
        result("postrst", 16'd9, 8'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/semiring_dot_pipe.md
SEMIRING_DOT_PIPE -- requirements
Module: semiring_dot_pipe

Interface
REQ-001 SHALL have parameter W, default 16: element width, unsigned.
REQ-002 SHALL have parameter N, default 4: lane pairs per beat, power of two, 2 to 16.
REQ-003 SHALL have parameter CW, default 8: beat-counter width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have in_valid  in  1; in_ready  out  1: input beat handshake.
REQ-007 SHALL have in_first  in  1; in_last  in  1: first/last beat of one dot product.
REQ-008 SHALL have in_op  in  2: 0 MIN_MAX, 1 MAX_MIN, 2 MIN_PLUS, 3 MAX_PLUS; sampled on first beat only.
REQ-009 SHALL have in_a, in_b  in  N*W: lane i at bits [i*W +: W]; in_c  in  W: accumulator seed, first beat only.
REQ-010 SHALL have out_valid  in/out: out 1; out_ready  in  1: result handshake.
REQ-011 SHALL have out_data  out  W; out_cnt  out  CW: beats folded in; out_err  out  1: illegal-mode flag.

Function
REQ-012 Modes SHALL be defined as (pair op, reduce op): MIN_MAX=(min,max), MAX_MIN=(max,min), MIN_PLUS=(add,min), MAX_PLUS=(add,max).
REQ-013 Add SHALL saturate to all-ones at W bits; min/max SHALL be unsigned compares.
REQ-014 Stage 1 SHALL register N pair results; stage 2 SHALL reduce-tree them and fold into the accumulator with the reduce op.
REQ-015 A first beat SHALL seed acc = reduce(in_c, tree); later beats SHALL compute acc = reduce(acc, tree).
REQ-016 A last beat SHALL produce out_valid exactly 2 cycles after its acceptance, with out_data = final acc and out_cnt = beats since first.
REQ-017 Throughput SHALL be one beat per cycle; in_ready = !out_valid || out_ready; the whole pipeline SHALL stall while out_valid && !out_ready.
REQ-018 out_data/out_cnt SHALL hold stable while out_valid && !out_ready.
REQ-019 A beat with in_first && in_last SHALL be a complete single-beat dot product, out_cnt=1.
REQ-020 in_first while a product is open SHALL discard the open accumulator and restart.
REQ-021 A beat without in_first when no product is open SHALL be treated as a first beat.
REQ-022 out_cnt SHALL saturate at 2^CW-1.
REQ-023 Inputs SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-024 rst_n low SHALL clear out_valid, out_data, out_cnt, out_err and the open-product flag to 0, asynchronously.
REQ-025 Reset mid-product SHALL discard all in-flight beats; no result SHALL emerge after reset release.
REQ-026 in_ready SHALL be 1 from the first cycle after reset release.

Configuration
REQ-027 Macro SEMIRING_PLUS_EN defined SHALL compile in MIN_PLUS and MAX_PLUS with saturating adders.
REQ-028 Without SEMIRING_PLUS_EN, op 2/3 SHALL execute as MIN_MAX, and that result SHALL carry out_err=1.
REQ-029 With SEMIRING_PLUS_EN, out_err SHALL be constant 0.

Structure
REQ-030 Package semiring_pkg SHALL hold the op enum, the mode-to-(pair,reduce) decode, and the min/max identity constants.
REQ-031 Sub-module semiring_reduce_tree (parameters W, N; combinational log2(N)-level tree, reduce-op select) SHALL be used by stage 2.

Verification (W=16, N=4, SEMIRING_PLUS_EN defined unless stated)
REQ-032 MIN_MAX single beat: a={3,9,5,1}, b={7,2,8,6}, c=0 -> out_data=5, out_cnt=1, out_valid 2 cycles after acceptance.
REQ-033 MIN_PLUS two beats: a={1,2,3,4}, b={10,1,5,0}, c=0xFFFF; then a={1,1,1,1}, b={1,9,9,9} -> out_data=2, out_cnt=2.
REQ-034 Saturation, MIN_PLUS: lanes a=0xFFF0, b=0x0020, c=0xFFFF -> out_data=0xFFFF.
REQ-035 Backpressure: out_ready=0 for 5 cycles on a pending result -> in_ready=0, out_data held; release -> no beat lost or duplicated.
REQ-036 Restart and reset: first beat, then in_first again with c=7, MAX_MIN, a=b={7,7,7,7} -> out_data=7, out_cnt=1; rst_n pulse mid-product -> no out_valid.
REQ-037 Without SEMIRING_PLUS_EN: op=2 on the REQ-032 vector -> out_data=5, out_err=1.
